inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 tb/tb_inst_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Circular-buffer instruction queue between fetch and decode.
//            Flush discards all entries; head outputs read zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [31:0]                  push_pc,
    input  logic [31:0]                  push_inst,
    input  logic                         push_addr_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_inst,
    output logic                         out_addr_err,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head_q;
    logic [c_PTR_W-1:0] w_head_d;
    logic [c_PTR_W-1:0] r_tail_q;
    logic [c_PTR_W-1:0] w_tail_d;
    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;

    logic [31:0] r_mem_pc   [DEPTH];
    logic [31:0] r_mem_inst [DEPTH];
    logic        r_mem_err  [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Status derives from the count register only, so push_ready never
    // depends combinationally on out_ready.
    assign w_full  = (r_count_q == c_CNT_W'(DEPTH));
    assign w_empty = (r_count_q == '0);
    assign w_push  = push_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    assign push_ready   = !w_full;
    assign out_valid    = !w_empty;
    assign count        = r_count_q;
    assign out_pc       = w_empty ? 32'd0 : r_mem_pc[r_head_q];
    assign out_inst     = w_empty ? 32'd0 : r_mem_inst[r_head_q];
    assign out_addr_err = w_empty ? 1'b0  : r_mem_err[r_head_q];

    always_comb begin
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end else begin
            if (w_push) begin
                w_tail_d = r_tail_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                w_head_d = r_head_q + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_count_d = r_count_q + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                w_count_d = r_count_q - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage carries no reset; empty-state masking hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem_pc[r_tail_q]   <= push_pc;
            r_mem_inst[r_tail_q] <= push_inst;
            r_mem_err[r_tail_q]  <= push_addr_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Directed scoreboard bench for inst_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_inst;
    logic        push_addr_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_addr_err;
    logic [3:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    ent_t sb[$];
    int   vectors;
    int   miscompares;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_pc      (push_pc),
        .push_inst    (push_inst),
        .push_addr_err(push_addr_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_addr_err (out_addr_err),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic err, input logic expect_accept);
        push_valid    = v;
        push_pc       = pc;
        push_inst     = inst;
        push_addr_err = err;
        if (v && expect_accept) sb.push_back('{pc: pc, inst: inst, err: err});
    endtask

    // Monitor: a pop is about to happen at the next rising edge.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got pc 0x%08h, expected no valid entry", out_pc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (out_pc !== e.pc || out_inst !== e.inst || out_addr_err !== e.err) begin
                    miscompares++;
                    $display("FAIL pop_data: got pc=0x%08h inst=0x%08h err=%0b expected pc=0x%08h inst=0x%08h err=%0b",
                             out_pc, out_inst, out_addr_err, e.pc, e.inst, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", {31'd0, out_addr_err}, 32'd0);

        // Single push into empty: visible one cycle later
        set_push(1'b1, 32'hBFC0_0000, 32'h2401_0001, 1'b0, 1'b1);
        tick();
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_pc", out_pc, 32'hBFC0_0000);
        chk("single_inst", out_inst, 32'h2401_0001);
        chk("single_count", {28'd0, count}, 32'd1);
        tick();
        chk("stall_hold_pc", out_pc, 32'hBFC0_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_empty_count", {28'd0, count}, 32'd0);
        chk("single_empty_pc", out_pc, 32'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 8; i++) begin
            set_push(1'b1, 32'(4 * i), 32'h1000 + 32'(i), i[0], 1'b1);
            tick();
        end
        set_push(1'b1, 32'h20, 32'h1008, 1'b0, 1'b0);
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_push_ready", {31'd0, push_ready}, 32'd0);
        tick();
        chk("full_ignore_count", {28'd0, count}, 32'd8);
        // Full plus pop in the same cycle: the push is still refused
        set_push(1'b1, 32'h24, 32'h1009, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("full_pop_count", {28'd0, count}, 32'd7);
        repeat (7) tick();
        out_ready = 1'b0;
        chk("drain_count", {28'd0, count}, 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Wrap-around: 6 in, 6 out, then 5 across index 7->0
        for (int i = 0; i < 6; i++) begin
            set_push(1'b1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, 32'h100 + 32'(4 * i), 32'h3000 + 32'(i), 1'b1, 1'b1);
            tick();
        end
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("wrap_count", {28'd0, count}, 32'd5);
        chk("wrap_head_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h300 + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        set_push(1'b1, 32'h30C, 32'h4003, 1'b1, 1'b1);
        out_ready = 1'b1;
        tick();
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        chk("simul_count", {28'd0, count}, 32'd3);
        chk("simul_head_pc", out_pc, 32'h304);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Flush with simultaneous push and pop at count 5
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, 32'h400 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        set_push(1'b1, 32'h500, 32'h6000, 1'b0, 1'b0);
        tick();
        sb.delete();
        flush = 1'b0;
        out_ready = 1'b0;
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("flush_count", {28'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // rst and flush together at count 4
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 32'h600 + 32'(4 * i), 32'h7000 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        sb.delete();
        rst = 1'b0;
        flush = 1'b0;
        chk("rstflush_count", {28'd0, count}, 32'd0);
        chk("rstflush_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rstflush_valid", {31'd0, out_valid}, 32'd0);
        set_push(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b1, 1'b1);
        tick();
        set_push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("post_rst_pc", out_pc, 32'h8000_0000);
        chk("post_rst_err", {31'd0, out_addr_err}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("final_count", {28'd0, count}, 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
